div_seq_2to1: RTL and testbench

- Sequential unsigned divider, the inverse of the 8x8 partial-product / 4:2-compressor multiplier.
- Takes a 2*DATA_LEN-bit dividend (product width) and a DATA_LEN-bit divisor. Returns a DATA_LEN-bit quotient and remainder, so that divisor*quotient + remainder == dividend.
- Radix-2 restoring algorithm, one quotient bit per clock.
- Valid/ready handshake on both sides; sits beside the multiplier in the arithmetic unit.

---
 rtl/div_seq_2to1.sv | 195 +++++++++++++++++++
 tb/tb_div_seq_2to1.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/div_seq_2to1.sv
// div_seq_2to1 -- sequential unsigned restoring divider.
//
// Divides a 2*DATA_LEN-bit dividend by a DATA_LEN-bit divisor and produces a
// DATA_LEN-bit quotient and remainder with divisor*quotient + remainder == dividend.
// One quotient bit is retired per clock (radix-2). Valid/ready handshake on
// both sides. There is no overlap: a new request is taken only in IDLE.
//
// Build option:
//   DIV_RADIX4_EN  defined   -> two cascaded restoring steps per clock
//                  undefined -> one restoring step per clock
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   request valid
//   in_ready   block is idle and can accept a request
//   dividend   2*DATA_LEN-bit unsigned dividend
//   divisor    DATA_LEN-bit unsigned divisor
//   out_valid  result valid (held until out_ready)
//   out_ready  consumer accepts result
//   quotient   DATA_LEN-bit quotient ('1 on divide-by-zero or overflow)
//   remainder  DATA_LEN-bit remainder
//   div_zero   divisor was zero
//   overflow   quotient would not fit in DATA_LEN bits (divisor nonzero)
//
// State | meaning
// IDLE  | waiting for a request, in_ready=1
// CALC  | restoring iterations in progress
// DONE  | result presented, waiting for out_ready
module div_seq_2to1 #(
    parameter int DATA_LEN = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2*DATA_LEN-1:0]   dividend,
    input  logic [DATA_LEN-1:0]     divisor,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_LEN-1:0]     quotient,
    output logic [DATA_LEN-1:0]     remainder,
    output logic                    div_zero,
    output logic                    overflow
);

`ifdef DIV_RADIX4_EN
    localparam int STEPS = 2;
`else
    localparam int STEPS = 1;
`endif
    localparam int CNT_W = $clog2(DATA_LEN);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DATA_LEN / STEPS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Partial remainder stays below the divisor between steps, so DATA_LEN
    // bits are enough to hold it; the extra bit only exists inside a step.
    logic [DATA_LEN-1:0] rem_q;
    logic [DATA_LEN-1:0] quo_q;
    logic [DATA_LEN-1:0] dvs_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                dz_q;
    logic                ov_q;

    logic accept;
    logic handoff;
    logic is_zero;
    logic is_ovf;

    assign accept  = in_valid && (state == IDLE);
    assign handoff = out_ready && (state == DONE);
    assign is_zero = (divisor == '0);
    assign is_ovf  = (dividend[2*DATA_LEN-1:DATA_LEN] >= divisor);

    // First restoring step: shift in the next dividend bit and trial-subtract.
    // The MSB of the DATA_LEN+1-bit difference is the borrow.
    logic [DATA_LEN:0]   sh1, t1;
    logic [DATA_LEN-1:0] r1, q1;

    always_comb begin
        sh1 = {rem_q, quo_q[DATA_LEN-1]};
        t1  = sh1 - {1'b0, dvs_q};
        r1  = t1[DATA_LEN] ? sh1[DATA_LEN-1:0] : t1[DATA_LEN-1:0];
        q1  = {quo_q[DATA_LEN-2:0], ~t1[DATA_LEN]};
    end

    logic [DATA_LEN-1:0] r_step, q_step;

`ifdef DIV_RADIX4_EN
    logic [DATA_LEN:0]   sh2, t2;

    always_comb begin
        sh2    = {r1, q1[DATA_LEN-1]};
        t2     = sh2 - {1'b0, dvs_q};
        r_step = t2[DATA_LEN] ? sh2[DATA_LEN-1:0] : t2[DATA_LEN-1:0];
        q_step = {q1[DATA_LEN-2:0], ~t2[DATA_LEN]};
    end
`else
    assign r_step = r1;
    assign q_step = q1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (is_zero || is_ovf) ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt_q == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (handoff) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
            dz_q  <= 1'b0;
            ov_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        dvs_q <= divisor;
                        cnt_q <= CNT_INIT;
                        // Divide-by-zero wins over overflow (0 <= anything).
                        if (is_zero) begin
                            quo_q <= '1;
                            rem_q <= dividend[DATA_LEN-1:0];
                            dz_q  <= 1'b1;
                        end else if (is_ovf) begin
                            quo_q <= '1;
                            rem_q <= '0;
                            ov_q  <= 1'b1;
                        end else begin
                            rem_q <= dividend[2*DATA_LEN-1:DATA_LEN];
                            quo_q <= dividend[DATA_LEN-1:0];
                        end
                    end
                end
                CALC: begin
                    rem_q <= r_step;
                    quo_q <= q_step;
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    // Quotient/remainder persist after the handoff; only flags clear.
                    if (handoff) begin
                        dz_q <= 1'b0;
                        ov_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign div_zero  = dz_q;
    assign overflow  = ov_q;

endmodule

// File: tb/tb_div_seq_2to1.sv
// Bench for div_seq_2to1 (DATA_LEN=8): directed cases, backpressure,
// mid-calculation reset, then random traffic through a scoreboard queue.
module tb_div_seq_2to1;

    localparam int DL = 8;
`ifdef DIV_RADIX4_EN
    localparam int LAT = DL / 2;
`else
    localparam int LAT = DL;
`endif
    localparam int NRAND = 3000;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [2*DL-1:0] dividend;
    logic [DL-1:0] divisor;
    logic          out_valid;
    logic          out_ready;
    logic [DL-1:0] quotient;
    logic [DL-1:0] remainder;
    logic          div_zero;
    logic          overflow;

    div_seq_2to1 #(.DATA_LEN(DL)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2*DL-1:0] dd;
        logic [DL-1:0]   dv;
        logic [DL-1:0]   q;
        logic [DL-1:0]   r;
        logic            dz;
        logic            ov;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [2*DL-1:0] dd, input logic [DL-1:0] dv);
        exp_t e;
        e.dd = dd;
        e.dv = dv;
        e.dz = 1'b0;
        e.ov = 1'b0;
        if (dv == 0) begin
            e.q  = '1;
            e.r  = dd[DL-1:0];
            e.dz = 1'b1;
        end else if (dd[2*DL-1:DL] >= dv) begin
            e.q  = '1;
            e.r  = '0;
            e.ov = 1'b1;
        end else begin
            e.q = DL'(dd / {8'd0, dv});
            e.r = DL'(dd % {8'd0, dv});
        end
        return e;
    endfunction

    function automatic exp_t pop_exp();
        exp_t e;
        if (sb.size() == 0) begin
            e.dd = '0; e.dv = '0; e.q = '0; e.r = '0; e.dz = 1'b0; e.ov = 1'b0;
            $display("FAIL sb_underflow got=empty exp=entry");
            n_errors++;
        end else begin
            e = sb.pop_front();
        end
        return e;
    endfunction

    // Full directed transaction: accept, latency, optional hold with out_ready=0,
    // handshake, and the post-handshake IDLE state.
    task automatic run_op(input logic [2*DL-1:0] dd, input logic [DL-1:0] dv,
                          input int hold, input bit poke);
        exp_t e;
        int   n;
        int   lat;
        e = model(dd, dv);
        lat = (e.dz || e.ov) ? 0 : LAT;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("idle_ready", in_ready, 1);
        in_valid = 1'b1;
        dividend = dd;
        divisor  = dv;
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        dividend = '0;
        divisor  = '0;
        n = 1;
        while (!out_valid && n < 40) begin
            check("busy_ready", in_ready, 0);
            @(negedge clk);
            n++;
        end
        check("latency", n - 1, lat);
        out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            if (poke) begin
                in_valid = 1'b1;
                dividend = 16'hFFFF;
                divisor  = 8'h01;
            end
            check("hold_out", {in_ready, out_valid, div_zero, overflow, quotient, remainder},
                  {1'b0, 1'b1, e.dz, e.ov, e.q, e.r});
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        e = pop_exp();
        check("result", {out_valid, div_zero, overflow, quotient, remainder},
              {1'b1, e.dz, e.ov, e.q, e.r});
        @(negedge clk);
        out_ready = 1'b0;
        check("post_hs", {out_valid, in_ready, div_zero, overflow, quotient, remainder},
              {1'b0, 1'b1, 1'b0, 1'b0, e.q, e.r});
    endtask

    initial begin
        exp_t        e;
        int          cyc;
        int          done_cnt;
        int          pushed;
        bit          taken;
        logic [2*DL-1:0] cur_dd;
        logic [DL-1:0]   cur_dv;
        logic [DL-1:0]   hi;

        rst       = 1'b1;
        in_valid  = 1'b0;
        dividend  = '0;
        divisor   = '0;
        out_ready = 1'b0;
        #2;
        check("reset_state", {in_ready, out_valid, div_zero, overflow, quotient, remainder},
              {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00});
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_op(16'h88EF, 8'hCD, 0, 1'b0);
        run_op(16'h88F0, 8'hCD, 0, 1'b0);
        run_op(16'hFE01, 8'hFF, 0, 1'b0);
        run_op(16'h1234, 8'h00, 0, 1'b0);
        run_op(16'h1234, 8'h12, 0, 1'b0);
        run_op(16'h0064, 8'h07, 5, 1'b1);

        // Asynchronous reset in the middle of CALC.
        in_valid = 1'b1;
        dividend = 16'h0064;
        divisor  = 8'h07;
        sb.push_back(model(16'h0064, 8'h07));
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (LAT / 2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("rst_calc", {out_valid, in_ready}, {1'b0, 1'b1});
        sb.delete();
        @(negedge clk);
        check("rst_hold", {out_valid, in_ready}, {1'b0, 1'b1});
        rst = 1'b0;
        @(negedge clk);
        run_op(16'h0051, 8'h09, 0, 1'b0);

        // Random traffic: in_valid held high, random out_ready.
        taken    = 1'b1;
        cyc      = 0;
        done_cnt = 0;
        pushed   = 0;
        cur_dd   = '0;
        cur_dv   = 8'h01;
        while (done_cnt < NRAND && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            if (taken) begin
                cur_dv = DL'($urandom_range(1, 255));
                hi     = DL'($urandom_range(0, int'(cur_dv) - 1));
                cur_dd = {hi, DL'($urandom_range(0, 255))};
                taken  = 1'b0;
            end
            in_valid = (pushed < NRAND);
            dividend = cur_dd;
            divisor  = cur_dv;
            if (in_valid && in_ready) begin
                sb.push_back(model(cur_dd, cur_dv));
                pushed++;
                taken = 1'b1;
            end
            out_ready = 1'($urandom_range(0, 1));
            if (out_valid && out_ready) begin
                e = pop_exp();
                check("rand_res", {div_zero, overflow, quotient, remainder},
                      {1'b0, 1'b0, e.q, e.r});
                check("rand_ident",
                      {15'd0, ({8'd0, quotient} * {8'd0, e.dv} + {8'd0, remainder}) == e.dd,
                       remainder < e.dv},
                      {15'd0, 1'b1, 1'b1});
                done_cnt++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("rand_done", done_cnt, NRAND);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
